// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front end.
// Provides FSM state enum, command codes and frame-width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int frame_w(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// spi_slave_bus: serial pins plus RAM-side rx/tx bundle.
// slave: ss_n/mosi/tx_* in, miso/rx_* out; master is the mirror.
interface spi_slave_bus #(
  parameter int DATA_W = 8
);
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: waits for the RAM byte, then shifts it out on miso.
// Ports: clk, rst_n, clear, start, tx_valid, tx_data in; miso out.
// Optional assertions with `define SPI_SLAVE_SVA_EN.
module spi_tx_serializer #(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso
);
  localparam int SH_W   = $clog2(DATA_W + 1);
  localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);

  logic [DATA_W-1:0] sr;
  logic [SH_W-1:0]   sh_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      sh_cnt   <= '0;
      wait_cnt <= '0;
      miso     <= 1'b0;
    end else if (clear) begin
      sr       <= '0;
      sh_cnt   <= '0;
      wait_cnt <= '0;
      miso     <= 1'b0;
    end else begin
      if (sh_cnt != '0) begin
        miso   <= sr[DATA_W-1];
        sr     <= {sr[DATA_W-2:0], 1'b0};
        sh_cnt <= sh_cnt - SH_W'(1);
      end else begin
        miso <= 1'b0;
      end
      // tx_valid only counts while the wait window is open
      if (start) begin
        wait_cnt <= WAIT_W'(TX_WAIT_MAX);
      end else if (wait_cnt != '0) begin
        if (tx_valid) begin
          sr       <= tx_data;
          sh_cnt   <= SH_W'(DATA_W);
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt - WAIT_W'(1);
        end
      end
    end
  end

`ifdef SPI_SLAVE_SVA_EN
  a_miso_idle: assert property (
    @(posedge clk) disable iff (!rst_n)
    miso |-> $past(sh_cnt) != '0);
`endif

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: deserialises cmd+payload frames, serialises read bytes.
// Ports: clk, rst_n, bus (spi_slave_bus.slave).
// Optional assertions/covers with `define SPI_SLAVE_SVA_EN.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 4
) (
  input logic        clk,
  input logic        rst_n,
  spi_slave_bus.slave bus
);
  localparam int FW    = frame_w(DATA_W);
  localparam int CNT_W = $clog2(FW + 1);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [FW-2:0]    shreg;
  logic [FW-1:0]    rx_data_q;
  logic             rx_valid_q;
  logic             rd_addr_done;
  logic             shifting;
  logic             done;
  logic             miso_w;

  assign shifting = state inside {WRITE, READ_ADD, READ_DATA};
  assign done = shifting && !bus.ss_n
             && (cnt == CNT_W'(FW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!bus.ss_n) state_nx = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.ss_n)            state_nx = IDLE;
        else if (!bus.mosi)      state_nx = WRITE;
        else if (rd_addr_done)   state_nx = READ_DATA;
        else                     state_nx = READ_ADD;
      end
      default: begin
        if (bus.ss_n) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      shreg        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (bus.ss_n || state == IDLE) begin
        cnt <= '0;
      end else if (state == CHK_CMD) begin
        shreg <= {shreg[FW-3:0], bus.mosi};
        cnt   <= CNT_W'(1);
      end else if (cnt < CNT_W'(FW)) begin
        // count parks at FW: later bits are ignored
        shreg <= {shreg[FW-3:0], bus.mosi};
        cnt   <= cnt + CNT_W'(1);
      end
      if (done) begin
        rx_data_q  <= {shreg, bus.mosi};
        rx_valid_q <= 1'b1;
        if (state == READ_ADD)
          rd_addr_done <= 1'b1;
        else if (state == READ_DATA)
          rd_addr_done <= 1'b0;
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W      (DATA_W),
    .TX_WAIT_MAX (TX_WAIT_MAX)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.ss_n),
    .start    (done && state == READ_DATA),
    .tx_valid (bus.tx_valid),
    .tx_data  (bus.tx_data),
    .miso     (miso_w)
  );

  assign bus.miso     = miso_w;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_SVA_EN
  a_rv_pulse: assert property (
    @(posedge clk) disable iff (!rst_n)
    rx_valid_q |=> !rx_valid_q);
  a_rv_src: assert property (
    @(posedge clk) disable iff (!rst_n)
    rx_valid_q |-> !($past(state) inside {IDLE, CHK_CMD}));
  a_ssn_idle: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.ss_n |=> state == IDLE);

  c_idle: cover property (
    @(posedge clk) disable iff (!rst_n) state == IDLE);
  c_chk: cover property (
    @(posedge clk) disable iff (!rst_n) state == CHK_CMD);
  c_wr: cover property (
    @(posedge clk) disable iff (!rst_n) state == WRITE);
  c_ra: cover property (
    @(posedge clk) disable iff (!rst_n) state == READ_ADD);
  c_rd: cover property (
    @(posedge clk) disable iff (!rst_n) state == READ_DATA);
  c_wa: cover property (
    @(posedge clk) disable iff (!rst_n)
    rx_valid_q && rx_data_q[FW-1:FW-2] == CMD_WR_ADDR);
  c_wd: cover property (
    @(posedge clk) disable iff (!rst_n)
    rx_valid_q && rx_data_q[FW-1:FW-2] == CMD_WR_DATA);
  c_rad: cover property (
    @(posedge clk) disable iff (!rst_n)
    rx_valid_q && rx_data_q[FW-1:FW-2] == CMD_RD_ADDR);
  c_rdd: cover property (
    @(posedge clk) disable iff (!rst_n)
    rx_valid_q && rx_data_q[FW-1:FW-2] == CMD_RD_DATA);
`endif

endmodule
